// File: rtl/cla_shared_seq_adder.sv
// cla_shared_seq_adder: two-requester sequential adder that walks one
// CHUNK-bit lookahead-carry slice across a WIDTH-bit operand, LSB slice first.
//
// state | meaning
// IDLE  | waiting for a request, round-robin grant between requesters
// BUSY  | one slice per cycle, carry registered between passes
// DONE  | result presented, held until res_ready

module cla_shared_seq_adder #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req0_cin,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic             req1_cin,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_sum,
  output logic             res_cout,
  output logic             res_ovf,
  output logic             res_id
);

  localparam int N     = WIDTH / CHUNK;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(N - 1);
  localparam logic [WIDTH-1:0] SLICE_MASK = WIDTH'({CHUNK{1'b1}});

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t             state, state_nxt;
  logic [WIDTH-1:0]   a_q, b_q, sum_work, next_sum;
  logic               carry, last_id;
  logic [IDX_W-1:0]   idx;
  logic               grant0, grant1, accept0, accept1;
  logic [CHUNK-1:0]   a_sl, b_sl, g, p, slice_sum;
  logic [CHUNK:0]     c;
  int                 base;

  // Round-robin grant: a lone requester always wins, a tie goes to the one not served last.
  always_comb begin
    grant0 = req0_valid & (~req1_valid | last_id);
    grant1 = req1_valid & (~req0_valid | ~last_id);
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept0 | accept1)      state_nxt = BUSY;
      BUSY: if (idx == LAST_IDX)        state_nxt = DONE;
      DONE: if (res_ready)              state_nxt = IDLE;
      default:                          state_nxt = IDLE;
    endcase
  end

  // Outputs: ready only in IDLE for the granted requester, forced low while reset is asserted.
  always_comb begin
    req0_ready = (state == IDLE) & grant0 & ~rst;
    req1_ready = (state == IDLE) & grant1 & ~rst;
    res_valid  = (state == DONE);
    accept0    = req0_valid & req0_ready;
    accept1    = req1_valid & req1_ready;
  end

  // One lookahead slice: every carry is a flat sum of generate/propagate products.
  always_comb begin
    logic term;
    logic acc;
    base = int'(idx) * CHUNK;
    a_sl = CHUNK'(a_q >> base);
    b_sl = CHUNK'(b_q >> base);
    g    = a_sl & b_sl;
    p    = a_sl ^ b_sl;
    c    = '0;
    c[0] = carry;
    for (int i = 0; i < CHUNK; i++) begin
      term = carry;
      for (int k = 0; k <= i; k++) term = term & p[k];
      acc = term;
      for (int j = 0; j <= i; j++) begin
        term = g[j];
        for (int k = j + 1; k <= i; k++) term = term & p[k];
        acc = acc | term;
      end
      c[i+1] = acc;
    end
    slice_sum = p ^ c[CHUNK-1:0];
    next_sum  = (sum_work & ~(SLICE_MASK << base)) | (WIDTH'(slice_sum) << base);
  end

  // Datapath: capture on accept, one slice per BUSY cycle, publish the result on the last pass.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q      <= '0;
      b_q      <= '0;
      carry    <= 1'b0;
      idx      <= '0;
      last_id  <= 1'b1;
      sum_work <= '0;
      res_sum  <= '0;
      res_cout <= 1'b0;
      res_ovf  <= 1'b0;
      res_id   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept0) begin
            a_q     <= req0_a;
            b_q     <= req0_b;
            carry   <= req0_cin;
            idx     <= '0;
            last_id <= 1'b0;
            res_id  <= 1'b0;
          end else if (accept1) begin
            a_q     <= req1_a;
            b_q     <= req1_b;
            carry   <= req1_cin;
            idx     <= '0;
            last_id <= 1'b1;
            res_id  <= 1'b1;
          end
        end
        BUSY: begin
          sum_work <= next_sum;
          carry    <= c[CHUNK];
          if (idx == LAST_IDX) begin
            res_sum  <= next_sum;
            res_cout <= c[CHUNK];
            res_ovf  <= c[CHUNK-1] ^ c[CHUNK];
          end else begin
            idx <= idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cla_shared_seq_adder.sv
// Bench for cla_shared_seq_adder at WIDTH=16, CHUNK=4.

module tb_cla_shared_seq_adder;

  localparam int W   = 16;
  localparam int C   = 4;
  localparam int N   = W / C;
  localparam int LAT = N + 1;

  logic         clk = 1'b0;
  logic         rst;
  logic         req0_valid, req0_ready, req0_cin;
  logic [W-1:0] req0_a, req0_b;
  logic         req1_valid, req1_ready, req1_cin;
  logic [W-1:0] req1_a, req1_b;
  logic         res_valid, res_ready, res_cout, res_ovf, res_id;
  logic [W-1:0] res_sum;

  int n_checks = 0;
  int n_fail   = 0;

  cla_shared_seq_adder #(.WIDTH(W), .CHUNK(C)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_cin(req0_cin),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_cin(req1_cin),
    .res_valid(res_valid), .res_ready(res_ready), .res_sum(res_sum), .res_cout(res_cout),
    .res_ovf(res_ovf), .res_id(res_id)
  );

  always #5 clk = ~clk;

  typedef struct {
    int           port;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic set_req(input int port, input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic cin);
    if (port == 0) begin
      req0_valid = v; req0_a = a; req0_b = b; req0_cin = cin;
    end else begin
      req1_valid = v; req1_a = a; req1_b = b; req1_cin = cin;
    end
  endtask

  // Called just after a negedge; returns just after a negedge with the result consumed.
  task automatic run_op(input int port, input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                        input logic [W-1:0] esum, input logic ecout, input logic eovf, input string tag);
    int   n;
    logic rdy;
    set_req(port, 1'b1, a, b, cin);
    #1;
    n   = 0;
    rdy = (port == 0) ? req0_ready : req1_ready;
    while (!rdy && n < 20) begin
      @(negedge clk); #1; n++;
      rdy = (port == 0) ? req0_ready : req1_ready;
    end
    check({tag, " grant"}, 32'(rdy), 32'd1);
    if (!rdy) begin
      set_req(port, 1'b0, '0, '0, 1'b0);
      return;
    end
    @(negedge clk);
    set_req(port, 1'b0, '0, '0, 1'b0);
    #1;
    n = 1;
    while (!res_valid && n < 20) begin
      @(negedge clk); #1; n++;
    end
    check({tag, " latency"}, 32'(n), 32'(LAT));
    check({tag, " sum"},  32'(res_sum),  32'(esum));
    check({tag, " cout"}, 32'(res_cout), 32'(ecout));
    check({tag, " ovf"},  32'(res_ovf),  32'(eovf));
    check({tag, " id"},   32'(res_id),   32'(port));
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    #1;
    check({tag, " valid drop"}, 32'(res_valid), 32'd0);
  endtask

  initial begin
    int           g_id[4], g_cyc[4], r_id[4];
    int           ng, nr, hs, n;
    logic [W-1:0] ra, rb, held;
    logic         rc, rp;
    logic [W:0]   full;

    vecs[0] = '{0, 16'h1234, 16'h1111, 1'b0, 16'h2345, 1'b0, 1'b0};
    vecs[1] = '{1, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[2] = '{0, 16'h7FFF, 16'h0000, 1'b1, 16'h8000, 1'b0, 1'b1};
    vecs[3] = '{1, 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
    vecs[4] = '{0, 16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};
    vecs[5] = '{1, 16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0, 1'b0};
    vecs[6] = '{0, 16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, 1'b0};
    vecs[7] = '{1, 16'h4000, 16'h4000, 1'b0, 16'h8000, 1'b0, 1'b1};

    rst = 1'b1;
    res_ready = 1'b0;
    set_req(0, 1'b0, '0, '0, 1'b0);
    set_req(1, 1'b0, '0, '0, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check("reset valid", 32'(res_valid), 32'd0);
    check("reset sum",   32'(res_sum),   32'd0);
    check("reset cout",  32'(res_cout),  32'd0);
    check("reset ovf",   32'(res_ovf),   32'd0);
    check("reset id",    32'(res_id),    32'd0);

    // Reset pulse while BUSY, between clock edges.
    set_req(0, 1'b1, 16'h00FF, 16'h0001, 1'b0);
    @(negedge clk);
    set_req(0, 1'b0, '0, '0, 1'b0);
    @(negedge clk);
    set_req(0, 1'b1, 16'h0001, 16'h0001, 1'b0);
    set_req(1, 1'b1, 16'h0001, 16'h0001, 1'b0);
    #1;
    check("busy ready0", 32'(req0_ready), 32'd0);
    #1 rst = 1'b1;
    #1;
    check("midrst valid",  32'(res_valid),  32'd0);
    check("midrst ready0", 32'(req0_ready), 32'd0);
    check("midrst ready1", 32'(req1_ready), 32'd0);
    set_req(0, 1'b0, '0, '0, 1'b0);
    set_req(1, 1'b0, '0, '0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    res_ready = 1'b1;
    repeat (6) @(negedge clk);
    #1;
    check("no stale result", 32'(res_valid), 32'd0);
    res_ready = 1'b0;

    for (int i = 0; i < 8; i++)
      run_op(vecs[i].port, vecs[i].a, vecs[i].b, vecs[i].cin,
             vecs[i].sum, vecs[i].cout, vecs[i].ovf, $sformatf("vec%0d", i));

    // Both requesters valid continuously: grants alternate, N+2 apart.
    set_req(0, 1'b1, 16'h0001, 16'h0002, 1'b0);
    set_req(1, 1'b1, 16'h0010, 16'h0020, 1'b0);
    res_ready = 1'b1;
    ng = 0; nr = 0;
    for (int cyc = 0; cyc < 30; cyc++) begin
      #1;
      if (ng < 4 && req0_valid && req0_ready) begin g_id[ng] = 0; g_cyc[ng] = cyc; ng++; end
      if (ng < 4 && req1_valid && req1_ready) begin g_id[ng] = 1; g_cyc[ng] = cyc; ng++; end
      if (nr < 4 && res_valid) begin
        r_id[nr] = int'(res_id);
        check($sformatf("rr sum%0d", nr), 32'(res_sum), res_id ? 32'h30 : 32'h3);
        nr++;
      end
      @(negedge clk);
    end
    check("rr grants", 32'(ng), 32'd4);
    check("rr results", 32'(nr), 32'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < ng) check($sformatf("rr grant%0d", i), 32'(g_id[i]), 32'(i % 2));
      if (i < nr) check($sformatf("rr id%0d", i), 32'(r_id[i]), 32'(i % 2));
      if (i > 0 && i < ng) check($sformatf("rr spacing%0d", i), 32'(g_cyc[i] - g_cyc[i-1]), 32'(N + 2));
    end
    set_req(0, 1'b0, '0, '0, 1'b0);
    set_req(1, 1'b0, '0, '0, 1'b0);
    repeat (10) @(negedge clk);
    res_ready = 1'b0;

    // Backpressure in DONE.
    set_req(0, 1'b1, 16'hAAAA, 16'h5555, 1'b1);
    #1;
    n = 0;
    while (!req0_ready && n < 20) begin @(negedge clk); #1; n++; end
    check("bp grant", 32'(req0_ready), 32'd1);
    @(negedge clk);
    set_req(0, 1'b0, '0, '0, 1'b0);
    #1;
    n = 0;
    while (!res_valid && n < 20) begin @(negedge clk); #1; n++; end
    check("bp reach done", 32'(res_valid), 32'd1);
    held = res_sum;
    check("bp sum", 32'(res_sum), 32'h0000);
    check("bp cout", 32'(res_cout), 32'd1);
    set_req(0, 1'b1, 16'h0001, 16'h0001, 1'b0);
    set_req(1, 1'b1, 16'h0001, 16'h0001, 1'b0);
    for (int cyc = 0; cyc < 10; cyc++) begin
      @(negedge clk); #1;
      check($sformatf("bp valid%0d", cyc), 32'(res_valid), 32'd1);
      check($sformatf("bp hold%0d", cyc), 32'(res_sum), 32'(held));
      check($sformatf("bp rdy%0d", cyc), {30'd0, req1_ready, req0_ready}, 32'd0);
    end
    set_req(0, 1'b0, '0, '0, 1'b0);
    set_req(1, 1'b0, '0, '0, 1'b0);
    res_ready = 1'b1;
    hs = 0;
    for (int cyc = 0; cyc < 8; cyc++) begin
      #1;
      if (res_valid && res_ready) hs++;
      @(negedge clk);
    end
    check("bp handshakes", 32'(hs), 32'd1);
    res_ready = 1'b0;

    // Random operands against A+B+cin.
    for (int i = 0; i < 1000; i++) begin
      ra   = W'($urandom);
      rb   = W'($urandom);
      rc   = 1'($urandom_range(0, 1));
      rp   = 1'($urandom_range(0, 1));
      full = {1'b0, ra} + {1'b0, rb} + {{W{1'b0}}, rc};
      run_op(int'(rp), ra, rb, rc, full[W-1:0], full[W],
             (ra[W-1] == rb[W-1]) && (full[W-1] != ra[W-1]), $sformatf("rnd%0d", i));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
